// File: rtl/biriscv_ifetch_bypass_pkg.sv
// Shared types for the uncached instruction-fetch bypass: privilege encodings
// and the fetch FSM state type.
package biriscv_ifetch_bypass_pkg;

    localparam logic [1:0] PRIV_USER       = 2'd0;
    localparam logic [1:0] PRIV_SUPER      = 2'd1;
    localparam logic [1:0] PRIV_MACHINE    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_RESP0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_RESP1 = 3'd4,
        ST_DONE  = 3'd5
    } fetch_state_t;

    // Fetches are always 8-byte aligned; the low PC bits are dropped.
    function automatic logic [31:0] fetch_base(input logic [31:0] pc);
        return {pc[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/biriscv_ifetch_bypass.sv
// Uncached icache stand-in: one 64-bit fetch becomes two 32-bit bus reads.
// Optional user-mode fetch limit enabled by defining IFETCH_PRIV_CHECK_EN.
module biriscv_ifetch_bypass
    import biriscv_ifetch_bypass_pkg::*;
#(
    parameter logic [31:0] USER_LIMIT_ADDR = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        icache_rd_i,
    input  logic [31:0] icache_pc_i,
    input  logic [1:0]  icache_priv_i,
    input  logic        icache_flush_i,
    input  logic        icache_invalidate_i,
    output logic        icache_accept_o,
    output logic        icache_valid_o,
    output logic [63:0] icache_inst_o,
    output logic        icache_error_o,
    output logic        icache_page_fault_o,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic        mem_error_i,
    input  logic [31:0] mem_data_i
);

    fetch_state_t state_reg, state_next;

    logic [31:0] base_reg;
    logic [1:0]  priv_reg;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] hi_reg, hi_next;
    logic        err_reg, err_next;
    logic        fault_reg, fault_next;
    logic        fault_active;

    logic [63:0] inst_reg;
    logic        valid_reg;
    logic        error_reg;
    logic        page_fault_reg;

    logic        capture;

    assign capture = (state_reg == ST_IDLE) && icache_rd_i;

`ifdef IFETCH_PRIV_CHECK_EN
    // The fault is decided at capture and resolved in REQ0, before any bus read.
    assign fault_next   = (icache_priv_i == PRIV_USER) &&
                          (fetch_base(icache_pc_i) >= USER_LIMIT_ADDR);
    assign fault_active = fault_reg;
`else
    assign fault_next   = 1'b0;
    assign fault_active = 1'b0;
`endif

    // Flush and invalidate have nothing to act on; priv only matters with the check.
    logic unused_inputs;
    assign unused_inputs = ^{icache_pc_i[2:0], icache_flush_i, icache_invalidate_i,
                             priv_reg, USER_LIMIT_ADDR, PRIV_SUPER, PRIV_MACHINE};

    always_comb begin
        state_next = state_reg;
        lo_next    = lo_reg;
        hi_next    = hi_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (icache_rd_i) begin
                    state_next = ST_REQ0;
                    lo_next    = 32'h0;
                    hi_next    = 32'h0;
                    err_next   = 1'b0;
                end
            end
            ST_REQ0: begin
                if (fault_active)
                    state_next = ST_DONE;
                else if (mem_accept_i)
                    state_next = ST_RESP0;
            end
            ST_RESP0: begin
                if (mem_ack_i) begin
                    lo_next  = mem_error_i ? 32'h0 : mem_data_i;
                    err_next = mem_error_i;
                    state_next = mem_error_i ? ST_DONE : ST_REQ1;
                end
            end
            ST_REQ1: begin
                if (mem_accept_i)
                    state_next = ST_RESP1;
            end
            ST_RESP1: begin
                if (mem_ack_i) begin
                    hi_next    = mem_error_i ? 32'h0 : mem_data_i;
                    err_next   = err_reg | mem_error_i;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            base_reg       <= 32'h0;
            priv_reg       <= 2'b00;
            lo_reg         <= 32'h0;
            hi_reg         <= 32'h0;
            err_reg        <= 1'b0;
            fault_reg      <= 1'b0;
            inst_reg       <= 64'h0;
            valid_reg      <= 1'b0;
            error_reg      <= 1'b0;
            page_fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
            err_reg   <= err_next;
            valid_reg <= (state_next == ST_DONE);
            if (capture) begin
                base_reg  <= fetch_base(icache_pc_i);
                priv_reg  <= icache_priv_i;
                fault_reg <= fault_next;
            end
            // Response registers change only on entry to DONE, so they hold between fetches.
            if (state_next == ST_DONE && state_reg != ST_DONE) begin
                inst_reg       <= fault_active ? 64'h0 : {hi_next, lo_next};
                error_reg      <= err_next;
                page_fault_reg <= fault_active;
            end
        end
    end

    always_comb begin
        mem_rd_o   = 1'b0;
        mem_addr_o = 32'h0;
        case (state_reg)
            ST_REQ0: begin
                mem_rd_o   = !fault_active;
                mem_addr_o = fault_active ? 32'h0 : base_reg;
            end
            ST_REQ1: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = base_reg + 32'd4;
            end
            default: begin
                mem_rd_o   = 1'b0;
                mem_addr_o = 32'h0;
            end
        endcase
    end

    assign icache_accept_o     = (state_reg == ST_IDLE);
    assign icache_valid_o      = valid_reg;
    assign icache_inst_o       = inst_reg;
    assign icache_error_o      = error_reg;
    assign icache_page_fault_o = page_fault_reg;

endmodule
